// File: rtl/usb_bulk_pktgen.sv
// rtl/usb_bulk_pktgen.sv - BULK IN test-pattern generator with optional BULK OUT loopback checker.
// Optional checker compiled in with macro PKTGEN_CHECKER_EN.
module usb_bulk_pktgen #(
  parameter int WIDTH = 8,
  parameter int LBITS = 10,
  parameter int GAP   = 4
) (
  input  logic             usb_clock,
  input  logic             arst_n,
  input  logic             enable_i,
  input  logic [2:0]       config_i,
  input  logic [LBITS-1:0] len_i,
  input  logic [1:0]       mode_i,
  output logic             m_tvalid,
  input  logic             m_tready,
  output logic             m_tlast,
  output logic [WIDTH-1:0] m_tdata,
  input  logic             s_tvalid,
  output logic             s_tready,
  input  logic             s_tlast,
  input  logic [WIDTH-1:0] s_tdata,
  output logic             busy_o,
  output logic [15:0]      pkt_count_o,
  output logic [15:0]      err_count_o
);

  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_GAP} state_t;

  localparam logic [15:0] SEED = 16'hACE1;

  state_t           state;
  logic [LBITS-1:0] len_q;
  logic [1:0]       mode_q;
  logic [LBITS-1:0] beat;
  logic [15:0]      lfsr;
  logic [15:0]      gap_cnt;

  // Fibonacci x^16+x^14+x^13+x^11+1, shifting right; taps land on bits 0,2,3,5.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction

  function automatic logic [WIDTH-1:0] pattern(input logic [1:0] mode,
                                               input logic [LBITS-1:0] k,
                                               input logic [15:0] s);
    logic [31:0] wide;
    case (mode)
      2'd1:    wide = {s, s};
      2'd2:    wide = {4{8'hA5}};
      default: wide = 32'(k);
    endcase
    return wide[WIDTH-1:0];
  endfunction

  logic             start;
  logic             fire;
  logic [LBITS-1:0] beat_nx;
  logic [15:0]      lfsr_nx;

  assign start   = enable_i && (config_i != 3'd0) && (len_i != '0);
  assign fire    = m_tvalid && m_tready;
  assign beat_nx = beat + 1'b1;
  assign lfsr_nx = lfsr_next(lfsr);

  always_ff @(posedge usb_clock or negedge arst_n) begin
    if (!arst_n) begin
      state       <= ST_IDLE;
      m_tvalid    <= 1'b0;
      m_tlast     <= 1'b0;
      m_tdata     <= '0;
      busy_o      <= 1'b0;
      pkt_count_o <= '0;
      len_q       <= '0;
      mode_q      <= '0;
      beat        <= '0;
      lfsr        <= SEED;
      gap_cnt     <= '0;
      s_tready    <= 1'b0;
    end else begin
      s_tready <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state    <= ST_SEND;
            busy_o   <= 1'b1;
            len_q    <= len_i;
            mode_q   <= mode_i;
            beat     <= '0;
            lfsr     <= SEED;
            m_tvalid <= 1'b1;
            m_tdata  <= pattern(mode_i, '0, SEED);
            m_tlast  <= (len_i == LBITS'(1));
          end
        end
        ST_SEND: begin
          if (fire) begin
            if (m_tlast) begin
              m_tvalid    <= 1'b0;
              m_tlast     <= 1'b0;
              pkt_count_o <= pkt_count_o + 16'd1;
              if (GAP == 0) begin
                state  <= ST_IDLE;
                busy_o <= 1'b0;
              end else begin
                state   <= ST_GAP;
                gap_cnt <= 16'(GAP);
              end
            end else begin
              beat    <= beat_nx;
              lfsr    <= lfsr_nx;
              m_tdata <= pattern(mode_q, beat_nx, lfsr_nx);
              m_tlast <= (beat_nx == len_q - 1'b1);
            end
          end
        end
        ST_GAP: begin
          if (gap_cnt <= 16'd1) begin
            state  <= ST_IDLE;
            busy_o <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt - 16'd1;
          end
        end
        default: begin
          state  <= ST_IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

`ifdef PKTGEN_CHECKER_EN
  // The checker regenerates the sequence from the generator's latched mode/len,
  // so it assumes the loopback carries the packet currently being generated.
  logic [LBITS-1:0] chk_idx;
  logic [15:0]      chk_lfsr;
  logic             s_fire;
  logic [WIDTH-1:0] chk_exp;
  logic [1:0]       err_inc;
  logic [16:0]      err_sum;

  assign s_fire  = s_tvalid && s_tready;
  assign chk_exp = pattern(mode_q, chk_idx, chk_lfsr);

  always_comb begin
    err_inc = 2'd0;
    if (s_fire && (s_tdata != chk_exp)) err_inc = err_inc + 2'd1;
    if (s_fire && (s_tlast != (chk_idx == len_q - 1'b1))) err_inc = err_inc + 2'd1;
    err_sum = {1'b0, err_count_o} + 17'(err_inc);
  end

  always_ff @(posedge usb_clock or negedge arst_n) begin
    if (!arst_n) begin
      chk_idx     <= '0;
      chk_lfsr    <= SEED;
      err_count_o <= '0;
    end else begin
      err_count_o <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
      if (s_fire) begin
        if (s_tlast) begin
          chk_idx  <= '0;
          chk_lfsr <= SEED;
        end else begin
          chk_idx  <= chk_idx + 1'b1;
          chk_lfsr <= lfsr_next(chk_lfsr);
        end
      end
    end
  end
`else
  logic unused_sink;
  assign unused_sink = ^{s_tvalid, s_tlast, s_tdata};
  assign err_count_o = '0;
`endif

endmodule

// File: tb/tb_usb_bulk_pktgen.sv
// tb/tb_usb_bulk_pktgen.sv - randomized scoreboard bench for usb_bulk_pktgen.
module tb_usb_bulk_pktgen;
  localparam int WIDTH = 8;
  localparam int LBITS = 10;
  localparam int GAP   = 4;

  logic             usb_clock = 1'b0;
  logic             arst_n    = 1'b0;
  logic             enable_i  = 1'b0;
  logic [2:0]       config_i  = 3'd0;
  logic [LBITS-1:0] len_i     = '0;
  logic [1:0]       mode_i    = 2'd0;
  logic             m_tvalid, m_tlast, s_tready, busy_o;
  logic             m_tready  = 1'b0;
  logic [WIDTH-1:0] m_tdata;
  logic [15:0]      pkt_count_o, err_count_o;
  logic [WIDTH-1:0] corrupt   = '0;
  logic             s_tvalid, s_tlast;
  logic [WIDTH-1:0] s_tdata;

  assign s_tvalid = m_tvalid;
  assign s_tlast  = m_tlast;
  assign s_tdata  = m_tdata ^ corrupt;

  usb_bulk_pktgen #(.WIDTH(WIDTH), .LBITS(LBITS), .GAP(GAP)) dut (
    .usb_clock(usb_clock), .arst_n(arst_n), .enable_i(enable_i), .config_i(config_i),
    .len_i(len_i), .mode_i(mode_i), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .m_tlast(m_tlast), .m_tdata(m_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .s_tlast(s_tlast), .s_tdata(s_tdata), .busy_o(busy_o),
    .pkt_count_o(pkt_count_o), .err_count_o(err_count_o));

  always #5 usb_clock = ~usb_clock;

  typedef struct { logic [7:0] data; logic last; } beat_t;
  beat_t sb[$];

  int checks = 0;
  int failures = 0;
  int exp_pkts = 0;
  bit ready_hold = 1'b0;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction

  function automatic logic [7:0] ref_beat(input int mode, input int k);
    logic [15:0] s;
    if (mode == 1) begin
      s = 16'hACE1;
      for (int i = 0; i < k; i++) s = lfsr_step(s);
      return s[7:0];
    end
    if (mode == 2) return 8'hA5;
    return 8'(k % 256);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic push_pkt(input int len, input int mode);
    for (int k = 0; k < len; k++) sb.push_back('{ref_beat(mode, k), k == len - 1});
  endtask

  task automatic wait_busy(input bit level, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(posedge usb_clock); #1;
      if (busy_o == level) ok = 1'b1;
    end
    if (!ok) check("busy_timeout", 0, 1);
  endtask

  task automatic start_pkt(input int len, input int mode, output bit ok);
    len_i    = LBITS'(len);
    mode_i   = 2'(mode);
    config_i = 3'($urandom_range(1, 7));
    enable_i = 1'b1;
    wait_busy(1'b1, 20, ok);
    if (ok) exp_pkts++;
  endtask

  task automatic finish_pkt(input int len);
    bit ok;
    int stray;
    len_i  = LBITS'($urandom);
    mode_i = 2'($urandom);
    if ($urandom_range(0, 1) == 0) enable_i = 1'b0;
    else config_i = 3'd0;
    wait_busy(1'b0, 20 * len + 60, ok);
    check("pkt_count", int'(pkt_count_o), exp_pkts % 65536);
    check("sb_drained", sb.size(), 0);
    stray = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge usb_clock); #1;
      if (m_tvalid || busy_o) stray++;
    end
    check("idle_after_pkt", stray, 0);
  endtask

  task automatic run_pkt(input int len, input int mode);
    bit ok;
    start_pkt(len, mode, ok);
    if (ok) push_pkt(len, mode);
    finish_pkt(len);
  endtask

  initial begin
    forever begin
      @(posedge usb_clock); #1;
      m_tready = ready_hold ? 1'b1 : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: pops expected beats on every handshake and checks stall stability.
  bit               stall = 1'b0;
  logic [WIDTH-1:0] p_data;
  logic             p_last;
  always @(negedge usb_clock) begin
    beat_t e;
    if (!arst_n) begin
      stall = 1'b0;
    end else begin
      if (stall) begin
        checks++;
        if (!m_tvalid || m_tdata != p_data || m_tlast != p_last) begin
          failures++;
          $display("FAIL stall_hold actual=%0b/%0h/%0b required=1/%0h/%0b",
                   m_tvalid, m_tdata, m_tlast, p_data, p_last);
        end
      end
      if (m_tvalid && m_tready) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL unexpected_beat actual=%0h required=none", m_tdata);
        end else begin
          e = sb.pop_front();
          if (m_tdata != e.data || m_tlast != e.last) begin
            failures++;
            $display("FAIL beat actual=%0h/%0b required=%0h/%0b", m_tdata, m_tlast, e.data, e.last);
          end
        end
      end
      stall  = m_tvalid && !m_tready;
      p_data = m_tdata;
      p_last = m_tlast;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok, found, seen;
    int low, busy_low, stray;

    repeat (3) @(posedge usb_clock);
    #1;
    check("rst_tvalid", m_tvalid, 0);
    check("rst_tlast", m_tlast, 0);
    check("rst_tdata", m_tdata, 0);
    check("rst_busy", busy_o, 0);
    check("rst_pkt_count", pkt_count_o, 0);
    check("rst_err_count", err_count_o, 0);
    check("rst_s_tready", s_tready, 0);
    arst_n = 1'b1;
    @(posedge usb_clock); #1;
    check("s_tready_out_of_reset", s_tready, 1);

    // len_i=0 and config_i=0 must both keep the generator idle.
    enable_i = 1'b1; config_i = 3'd1; len_i = '0;
    stray = 0;
    for (int i = 0; i < 10; i++) begin @(posedge usb_clock); #1; if (m_tvalid || busy_o) stray++; end
    check("len0_idle", stray, 0);
    config_i = 3'd0; len_i = LBITS'(5);
    stray = 0;
    for (int i = 0; i < 10; i++) begin @(posedge usb_clock); #1; if (m_tvalid || busy_o) stray++; end
    check("cfg0_idle", stray, 0);
    enable_i = 1'b0;

    // Back-to-back count packets of 4 with enable held: measure the inter-packet gap.
    ready_hold = 1'b1;
    @(posedge usb_clock); #1;
    start_pkt(4, 0, ok);
    if (ok) for (int k = 0; k < 4; k++) sb.push_back('{8'(k), k == 3});
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (m_tvalid && m_tlast) found = 1'b1;
      else begin @(posedge usb_clock); #1; end
    end
    low = 0; busy_low = 0; seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(posedge usb_clock); #1;
      if (m_tvalid) seen = 1'b1;
      else begin low++; if (!busy_o) busy_low++; end
    end
    if (seen) begin
      for (int k = 0; k < 4; k++) sb.push_back('{8'(k), k == 3});
      exp_pkts++;
    end
    check("gap_tvalid_low", low, GAP + 1);
    check("gap_idle_cycles", busy_low, 1);
    finish_pkt(4);

    // LFSR packet of 3, twice: fixed reference values from seed 0xACE1.
    for (int r = 0; r < 2; r++) begin
      start_pkt(3, 1, ok);
      if (ok) begin
        sb.push_back('{8'hE1, 1'b0});
        sb.push_back('{8'h70, 1'b0});
        sb.push_back('{8'h38, 1'b1});
      end
      finish_pkt(3);
    end

    // Randomized packets with random backpressure.
    ready_hold = 1'b0;
    run_pkt(1, 0);
    run_pkt(8, 2);
    run_pkt(300, 0);
    for (int n = 0; n < 25; n++) run_pkt($urandom_range(1, 20), $urandom_range(0, 3));

`ifdef PKTGEN_CHECKER_EN
    check("err_count_clean", err_count_o, 0);
    ready_hold = 1'b1;
    @(posedge usb_clock); #1;
    start_pkt(4, 0, ok);
    if (ok) push_pkt(4, 0);
    corrupt = 8'h10;
    @(posedge usb_clock); #1;
    corrupt = '0;
    finish_pkt(4);
    check("err_count_corrupt", err_count_o, 1);
`else
    check("err_count_zero", err_count_o, 0);
`endif

    // Reset at beat 5 of a 16-beat packet: discard, then restart from beat 0.
    ready_hold = 1'b1;
    @(posedge usb_clock); #1;
    start_pkt(16, 0, ok);
    if (ok) push_pkt(16, 0);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (m_tvalid && m_tdata == 8'd5) found = 1'b1;
      else begin @(posedge usb_clock); #1; end
    end
    check("reached_beat5", found, 1);
    #2;
    arst_n = 1'b0;
    #1;
    check("arst_tvalid", m_tvalid, 0);
    check("arst_tdata", m_tdata, 0);
    check("arst_tlast", m_tlast, 0);
    check("arst_busy", busy_o, 0);
    check("arst_pkt_count", pkt_count_o, 0);
    check("arst_s_tready", s_tready, 0);
    sb.delete();
    exp_pkts = 0;
    @(posedge usb_clock); #1;
    arst_n = 1'b1;
    wait_busy(1'b1, 20, ok);
    if (ok) begin
      push_pkt(16, 0);
      exp_pkts = 1;
    end
    check("pkt_count_after_reset", pkt_count_o, 0);
    finish_pkt(16);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/usb_bulk_pktgen.md
USB_BULK_PKTGEN -- requirements
Module: usb_bulk_pktgen

Interface
REQ-001 SHALL have parameter WIDTH, default 8, the stream data width in bits (8, 16 or 32).
REQ-002 SHALL have parameter LBITS, default 10, the packet-length field width (max 2^LBITS-1 beats).
REQ-003 SHALL have parameter GAP, default 4, the idle cycles inserted between packets (0 allowed).
REQ-004 usb_clock  input  1  -- sole clock; all logic rising-edge.
REQ-005 arst_n  input  1  -- reset, asynchronous, active-low.
REQ-006 enable_i  input  1  -- device configured (from USB core configured_o).
REQ-007 config_i  input  3  -- USB configuration value; generation requires nonzero.
REQ-008 len_i  input  LBITS  -- beats per packet, sampled at packet start.
REQ-009 mode_i  input  2  -- pattern select, sampled at packet start: 0 count, 1 LFSR, 2 constant 0xA5 replicated, 3 reserved (treated as 0).
REQ-010 m_tvalid/m_tready/m_tlast  out/in/out  1  -- AXI-S source toward BULK IN.
REQ-011 m_tdata  output  WIDTH  -- source data.
REQ-012 s_tvalid/s_tready/s_tlast  in/out/in  1  -- AXI-S sink from BULK OUT (loopback check).
REQ-013 s_tdata  input  WIDTH  -- sink data.
REQ-014 busy_o  output  1  -- high while FSM not IDLE.
REQ-015 pkt_count_o  output  16  -- packets fully sent (tlast handshake), wraps at 0xFFFF->0.
REQ-016 err_count_o  output  16  -- checker mismatches, saturates at 0xFFFF.

Function
REQ-017 FSM states IDLE, SEND, GAP; IDLE->SEND when enable_i=1, config_i!=0, len_i!=0; SEND->GAP on tlast handshake; GAP->IDLE after GAP cycles (GAP=0: SEND->IDLE directly).
REQ-018 On IDLE->SEND, len_i and mode_i SHALL be latched; changes mid-packet have no effect.
REQ-019 m_tvalid SHALL assert the cycle after leaving IDLE and, once high, SHALL hold with stable m_tdata/m_tlast until m_tready=1.
REQ-020 m_tlast SHALL be high exactly on beat len-1 (beat index from 0); len=1 gives single-beat packet with tlast on first beat.
REQ-021 Count mode: beat k data = k mod 2^WIDTH, restarting at 0 each packet.
REQ-022 LFSR mode: 16-bit Fibonacci x^16+x^14+x^13+x^11+1, seed 0xACE1 each packet, one step per accepted beat; data = low WIDTH bits (WIDTH=32: {state, state} ).
REQ-023 enable_i or config_i dropping mid-packet SHALL NOT truncate; the current packet completes, then FSM returns to IDLE and stays.
REQ-024 len_i=0 in IDLE SHALL keep FSM in IDLE with m_tvalid=0.
REQ-025 pkt_count_o SHALL increment the cycle after each m_tvalid&m_tready&m_tlast.

Reset
REQ-026 arst_n low SHALL immediately force IDLE, m_tvalid=0, m_tlast=0, m_tdata=0, busy_o=0, pkt_count_o=0, err_count_o=0, checker beat index=0; s_tready=0 while reset asserted.
REQ-027 Reset mid-packet SHALL discard the packet; after release the next packet restarts from beat 0 with fresh seed.

Configuration
REQ-028 Macro PKTGEN_CHECKER_EN: defined -> loopback checker compiled in; s_tready=1 out of reset; each s_tvalid beat compared with the expected sequence regenerated from latched mode/len; data mismatch, s_tlast on wrong beat, or missing s_tlast on beat len-1 each add 1 to err_count_o; checker index resets on every s_tlast.
REQ-029 Macro undefined -> no checker logic; s_tready tied 1 out of reset, err_count_o constant 0, s_* inputs ignored.

Verification
REQ-030 WIDTH=8, len_i=4, mode 0, m_tready=1 -> m_tdata 00,01,02,03, tlast on 03, then 4 idle cycles, pkt_count_o=1.
REQ-031 mode 1, len_i=3, WIDTH=8 -> m_tdata E1, then low bytes of next two LFSR states (from 0xACE1), identical each packet.
REQ-032 m_tready toggling 1,0,0,1 mid-packet -> m_tdata/m_tlast held stable across stalls, no beat skipped or repeated.
REQ-033 enable_i deasserted at beat 2 of len 8 -> beats 3..7 still sent with tlast on 7, then busy_o=0 and m_tvalid stays 0.
REQ-034 With PKTGEN_CHECKER_EN, m_* looped to s_*, 10 packets -> err_count_o=0; corrupt one byte -> err_count_o=1.
REQ-035 arst_n pulsed low at beat 5 of len 16 -> outputs zero asynchronously; after release packet restarts at data 00, pkt_count_o=0.
